truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Downstream response checker for the 3-input combinational DUT stage. It samples the 3-bit input vector the stimulus counter applies and the DUT's 1-bit output. It checks each sample against an expected 8-entry truth table and confirms the vector advances by exactly +1 mod 8 per sample. Over a programmable number of full sweeps it accumulates the observed truth table, a saturating mismatch count and the first failing vector, then reports a single pass/fail verdict.

## Interface
- EXP_TT, 8'b1110_1000, expected output; bit i is the expected result for vector i
- SWEEPS, 2, number of complete 8-vector sweeps per run (≥1)
- CNT_W, 8, width of the mismatch counter
- clk  in  1  single clock, all state updates on its rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  one-cycle pulse that begins a run; ignored while busy
- vec_valid  in  1  vec/dut_out are a valid sample this cycle
- vec  in  3  input vector applied to the DUT, {a,b,c}, a = MSB
- dut_out  in  1  DUT output for vec
- busy  out  1  run in progress (ALIGN or SWEEP)
- done  out  1  run finished; verdict outputs are valid
- pass  out  1  done & no mismatch & no sequence error
- seq_err  out  1  a sampled vector was not previous+1 mod 8
- err_cnt  out  CNT_W  mismatch count, saturates at all-ones
- first_err_vec  out  3  vector of the first mismatch
- first_err_valid  out  1  first_err_vec holds a captured value
- tt_obs  out  8  observed truth table; bit i = last dut_out seen for vector i

## Operation
- States: IDLE, ALIGN, SWEEP, DONE. Reset to IDLE. All outputs are 0 in reset.
- IDLE: start → ALIGN. On the transition, clear err_cnt, seq_err, first_err_*, tt_obs and the sample counter.
- ALIGN: samples are ignored until one arrives with vec_valid=1 and vec=3'd0. That sample is processed as sample 0, and the state moves to SWEEP.
- SWEEP, for each valid sample:
  - tt_obs[vec] ← dut_out.
  - Mismatch when dut_out ≠ EXP_TT[vec]. Increment err_cnt, saturating. On the first mismatch, capture first_err_vec ← vec and set first_err_valid.
  - If vec ≠ (previous vec + 1) mod 8, set seq_err, which is sticky. The sample is still checked. The expected next vector becomes vec + 1.
  - A sample counter, width clog2(8·SWEEPS + 1), increments. When it reaches 8·SWEEPS − 1, this sample is the last and the state moves to DONE.
- A cycle without vec_valid is a stall: no state change, no error.
- DONE: done=1 and pass=(err_cnt==0 & ~seq_err). All results hold until the next start.
- A start in DONE re-enters ALIGN, clearing results the same way as from IDLE.
- A start while busy is ignored.
- rst at any time, mid-run included, returns to IDLE with all outputs 0 on the next edge.

## Timing
- Every sample is registered on the rising edge where vec_valid=1. Its effect on tt_obs, err_cnt, seq_err and first_err_* is visible the following cycle, so latency is 1.
- busy rises the cycle after start is sampled.
- done and pass rise the cycle after the final sample is registered; busy falls in that same cycle.
- A back-to-back valid stream must be accepted every cycle with no bubbles. The minimum run is therefore 8·SWEEPS samples after alignment.
- Wrap-around: vec 7 → 0 is a legal increment, with no seq_err.
- Saturation: at err_cnt = 2^CNT_W − 1, further mismatches leave the count unchanged.
- When start and rst are high in the same cycle, rst wins.

## Structure
- The shared package holds:
  - the state enum (IDLE, ALIGN, SWEEP, DONE);
  - VEC_W=3 and TT_W=8 constants;
  - the default expected-table constant.
- One sub-module, sat_counter (parameterised width, with clear and inc, saturating), is used for err_cnt.
- The FSM, sample counter and capture registers stay in the top module.

## Test plan
- Clean run with EXP_TT=8'hE8 and a DUT model implementing majority, start, then 16 consecutive vectors 0..7,0..7 → done and pass go high 1 cycle after the 16th sample; tt_obs=8'hE8, err_cnt=0, seq_err=0.
- Fault run with dut_out inverted at vec=3 in both sweeps → err_cnt=2, first_err_vec=3, first_err_valid=1, pass=0, tt_obs=8'hE0.
- Alignment and stall: the stream starts at vec=5, and vec_valid drops for 3 cycles mid-sweep → samples 5..7 are ignored; the run completes after 16 aligned samples; pass=1.
- Sequence error: the stream skips from vec 4 to vec 6 → seq_err=1 and pass=0; the run still ends after 16 samples.
- Reset mid-run: rst is pulsed after 9 samples → the next cycle shows busy=0, done=0, err_cnt=0, tt_obs=0; a following start produces a clean pass.
- Saturation with CNT_W=2 and the DUT output always inverted → err_cnt stops at 3, pass=0; a restart from DONE clears err_cnt to 0.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth-table response checker.
// Holds the FSM state encoding, vector/table widths and the default expected table.
package truth_table_checker_pkg;

  localparam int VEC_W = 3;
  localparam int TT_W  = 8;

  // Majority function of {a,b,c}: vectors 3,5,6,7 produce 1.
  localparam logic [TT_W-1:0] DEFAULT_EXP_TT = 8'b1110_1000;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    SWEEP,
    DONE
  } state_t;

  function automatic logic [VEC_W-1:0] next_vec(input logic [VEC_W-1:0] v);
    return v + VEC_W'(1);
  endfunction

endpackage

// File: rtl/truth_table_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Response checker for a 3-input combinational stage: compares sampled outputs
// against an expected truth table over several sweeps and reports a verdict.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter logic [TT_W-1:0] EXP_TT = DEFAULT_EXP_TT,
  parameter int              SWEEPS = 2,
  parameter int              CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              vec_valid,
  input  logic [VEC_W-1:0]  vec,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              seq_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [VEC_W-1:0]  first_err_vec,
  output logic              first_err_valid,
  output logic [TT_W-1:0]   tt_obs
);

  localparam int TOTAL = TT_W * SWEEPS;
  localparam int SMP_W = $clog2(TOTAL + 1);
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(TOTAL - 1);

  state_t            state;
  state_t            state_next;
  logic [SMP_W-1:0]  smp_cnt;
  logic [VEC_W-1:0]  vec_expect;
  logic              launch;
  logic              accept;
  logic              mismatch;
  logic              last_smp;

  // A sample counts only once aligned on vector 0; the aligning sample is sample 0.
  always_comb begin
    launch   = start && ((state == IDLE) || (state == DONE));
    accept   = vec_valid && (((state == ALIGN) && (vec == '0)) || (state == SWEEP));
    mismatch = accept && (dut_out != EXP_TT[vec]);
    last_smp = accept && (state == SWEEP) && (smp_cnt == LAST_SMP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)    state_next = ALIGN;
      ALIGN:   if (accept)   state_next = SWEEP;
      SWEEP:   if (last_smp) state_next = DONE;
      DONE:    if (start)    state_next = ALIGN;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ALIGN) || (state == SWEEP);
    done = (state == DONE);
    pass = (state == DONE) && (err_cnt == '0) && !seq_err;
  end

  // Results are cleared on each launch so a restart from DONE behaves like one from IDLE.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      smp_cnt         <= '0;
      vec_expect      <= '0;
      seq_err         <= 1'b0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      tt_obs          <= '0;
    end else if (accept) begin
      tt_obs[vec] <= dut_out;
      smp_cnt     <= smp_cnt + SMP_W'(1);
      vec_expect  <= next_vec(vec);
      if ((state == SWEEP) && (vec != vec_expect)) begin
        seq_err <= 1'b1;
      end
      if (mismatch && !first_err_valid) begin
        first_err_vec   <= vec;
        first_err_valid <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (launch),
    .inc   (mismatch),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: scenario table, hand-written corner sequences and random
// streams compared against a stream-level reference model of the checker.
module tb_truth_table_checker;

  localparam int N_SAMPLES = 16;

  logic       clk = 1'b0;
  logic       rst, start, vec_valid, dut_out;
  logic [2:0] vec;

  logic       busy, done, pass, seq_err, first_err_valid;
  logic [7:0] err_cnt, tt_obs;
  logic [2:0] first_err_vec;

  logic       busy_s, done_s, pass_s, seq_err_s, fev_valid_s;
  logic [1:0] err_cnt_s;
  logic [7:0] tt_obs_s;
  logic [2:0] fev_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.EXP_TT(8'hE8), .SWEEPS(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .seq_err(seq_err),
    .err_cnt(err_cnt), .first_err_vec(first_err_vec),
    .first_err_valid(first_err_valid), .tt_obs(tt_obs)
  );

  truth_table_checker #(.EXP_TT(8'hE8), .SWEEPS(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_out(dut_out), .busy(busy_s), .done(done_s), .pass(pass_s), .seq_err(seq_err_s),
    .err_cnt(err_cnt_s), .first_err_vec(fev_s),
    .first_err_valid(fev_valid_s), .tt_obs(tt_obs_s)
  );

  typedef struct {
    bit valid;
    int v;
    bit out;
  } sample_t;

  typedef struct {
    int start_vec;
    int stall_after;
    int fault_vec;
    bit invert_all;
    int skip_from;
    int mid_start;
    bit rnd;
  } run_cfg_t;

  typedef struct {
    run_cfg_t   cfg;
    logic [7:0] tt;
    int         err;
    int         err_s;
    bit         fev_valid;
    int         fev;
    bit         seq;
    bit         pass;
  } vector_t;

  typedef struct {
    int last_idx;
    int tt;
    int errs;
    bit fev_valid;
    int fev;
    bit seq;
  } model_t;

  sample_t hist[$];

  function automatic bit majority(int v);
    return (((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)) >= 2;
  endfunction

  function automatic int sat(int x, int w);
    int mx = (1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  // Replays the recorded stream: align on the first valid 0, then take 16 valid samples.
  function automatic model_t runModel();
    model_t m;
    int     n = 0;
    int     prev = 0;
    bit     aligned = 0;
    m = '{default: 0};
    m.last_idx = -1;
    foreach (hist[i]) begin
      if (!hist[i].valid) continue;
      if (!aligned) begin
        if (hist[i].v != 0) continue;
        aligned = 1;
      end else if (hist[i].v != (prev + 1) % 8) begin
        m.seq = 1;
      end
      if (hist[i].out) m.tt = m.tt | (1 << hist[i].v);
      else             m.tt = m.tt & ~(1 << hist[i].v);
      if (hist[i].out != majority(hist[i].v)) begin
        m.errs++;
        if (!m.fev_valid) begin
          m.fev_valid = 1;
          m.fev = hist[i].v;
        end
      end
      prev = hist[i].v;
      n++;
      if (n == N_SAMPLES) begin
        m.last_idx = i;
        break;
      end
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input run_cfg_t c);
    int      cur = c.start_vec;
    int      nvalid = 0;
    int      stall_left = 0;
    bit      stalled = 0;
    bit      skipped = 0;
    bit      seen_done = 0;
    int      done_idx = -1;
    int      cyc = 0;
    sample_t s;
    model_t  m;
    hist.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    while (!seen_done && cyc < 400) begin
      if (c.stall_after >= 0 && nvalid == c.stall_after && !stalled) begin
        stall_left = 3;
        stalled = 1;
      end
      if (c.rnd) s.valid = ($urandom_range(3) != 0);
      else       s.valid = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      s.v   = cur;
      s.out = majority(cur) ^ (c.invert_all || cur == c.fault_vec ||
                               (c.rnd && $urandom_range(7) == 0));
      vec_valid = s.valid;
      vec       = cur[2:0];
      dut_out   = s.out;
      start     = (cyc == c.mid_start);
      hist.push_back(s);
      if (s.valid) begin
        nvalid++;
        if (c.rnd && $urandom_range(9) == 0) cur = $urandom_range(7);
        else if (cur == c.skip_from && !skipped) begin
          cur = (cur + 2) % 8;
          skipped = 1;
        end else cur = (cur + 1) % 8;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen_done = 1;
        done_idx = cyc;
      end else begin
        checkOutput("busy_during_run", busy, 1);
      end
      cyc++;
    end
    vec_valid = 1'b0;
    vec = '0;
    dut_out = 1'b0;
    m = runModel();
    checkOutput("done_reached", seen_done, 1);
    checkOutput("done_latency", done_idx, m.last_idx);
    checkOutput("busy_at_done", busy, 0);
    checkOutput("model_tt_obs", tt_obs, m.tt);
    checkOutput("model_err_cnt", err_cnt, sat(m.errs, 8));
    checkOutput("model_err_cnt_sat", err_cnt_s, sat(m.errs, 2));
    checkOutput("model_first_err_valid", first_err_valid, m.fev_valid);
    if (m.fev_valid) checkOutput("model_first_err_vec", first_err_vec, m.fev);
    checkOutput("model_seq_err", seq_err, m.seq);
    checkOutput("model_pass", pass, (m.errs == 0) && !m.seq);
    checkOutput("model_pass_sat", pass_s, (m.errs == 0) && !m.seq);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vector_t  tbl[5];
  run_cfg_t rc;

  initial begin
    // start_vec, stall_after, fault_vec, invert_all, skip_from, mid_start, rnd
    tbl[0] = '{'{0, -1, -1, 0, -1, -1, 0}, 8'hE8, 0,  0, 0, 0, 0, 1};
    tbl[1] = '{'{0, -1,  3, 0, -1, -1, 0}, 8'hE0, 2,  2, 1, 3, 0, 0};
    tbl[2] = '{'{5,  8, -1, 0, -1,  6, 0}, 8'hE8, 0,  0, 0, 0, 0, 1};
    tbl[3] = '{'{0, -1, -1, 0,  4, -1, 0}, 8'hE8, 0,  0, 0, 0, 1, 0};
    tbl[4] = '{'{0, -1, -1, 1, -1, -1, 0}, 8'h17, 16, 3, 1, 0, 0, 0};

    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = '0; dut_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_err_cnt", err_cnt, 0);
    checkOutput("reset_tt_obs", tt_obs, 0);
    checkOutput("reset_first_err_valid", first_err_valid, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] scenario %0d", i);
      applyStimulus(tbl[i].cfg);
      checkOutput($sformatf("tbl%0d_done", i), done, 1);
      checkOutput($sformatf("tbl%0d_tt_obs", i), tt_obs, tbl[i].tt);
      checkOutput($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].err);
      checkOutput($sformatf("tbl%0d_err_cnt_sat", i), err_cnt_s, tbl[i].err_s);
      checkOutput($sformatf("tbl%0d_first_err_valid", i), first_err_valid, tbl[i].fev_valid);
      if (tbl[i].fev_valid)
        checkOutput($sformatf("tbl%0d_first_err_vec", i), first_err_vec, tbl[i].fev);
      checkOutput($sformatf("tbl%0d_seq_err", i), seq_err, tbl[i].seq);
      checkOutput($sformatf("tbl%0d_pass", i), pass, tbl[i].pass);
    end

    // Restart from DONE after the all-inverted run must clear the saturated count.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_done", done, 0);
    checkOutput("restart_err_cnt", err_cnt, 0);
    checkOutput("restart_err_cnt_sat", err_cnt_s, 0);
    checkOutput("restart_tt_obs", tt_obs, 0);
    pulseReset();

    // Reset mid-run after 9 samples, vector 1 corrupted.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      vec_valid = 1'b1;
      vec = k[2:0];
      dut_out = majority(k % 8) ^ (k == 1);
      @(posedge clk); #1;
    end
    checkOutput("midrun_err_cnt", err_cnt, 1);
    checkOutput("midrun_tt_obs", tt_obs, 8'hEA);
    checkOutput("midrun_first_err_vec", first_err_vec, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vec_valid = 1'b0;
    checkOutput("postrst_busy", busy, 0);
    checkOutput("postrst_done", done, 0);
    checkOutput("postrst_err_cnt", err_cnt, 0);
    checkOutput("postrst_tt_obs", tt_obs, 0);
    checkOutput("postrst_first_err_valid", first_err_valid, 0);
    applyStimulus(tbl[0].cfg);
    checkOutput("postrst_clean_pass", pass, 1);

    // rst and start together from DONE: reset wins.
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rst_start_busy", busy, 0);
    checkOutput("rst_start_done", done, 0);
    checkOutput("rst_start_tt_obs", tt_obs, 0);

    for (int r = 0; r < 8; r++) begin
      rc = '{$urandom_range(7), -1, -1, 0, -1, $urandom_range(12), 1};
      $display("[TB] random run %0d", r);
      applyStimulus(rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
